move_sequencer: RTL and testbench

Multi-cycle controller that executes one complete Reversi move on the 64-cell packed board. A move request gives a cell index and the side to move. The block checks that the cell is empty, then walks all eight directions one cell per cycle. Every opponent run that is capped by an own disc is flipped, and the new disc is written. It sits between the game FSM and the board register: it returns the updated board, a legal flag, the flip count and the next side to move.

---
 rtl/reversi_pkg.sv | 27 ++
 rtl/board_step.sv | 24 ++
 rtl/move_sequencer.sv | 174 +++++++++++++++++
 tb/tb_move_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/reversi_pkg.sv
// Shared Reversi definitions: cell codes, direction tables and sequencer state encoding.
package reversi_pkg;

    localparam int unsigned BOARD_W = 192;

    localparam logic [2:0] CELL_EMPTY = 3'b000;
    localparam logic [2:0] CELL_BLACK = 3'b111;
    localparam logic [2:0] CELL_WHITE = 3'b110;

    typedef enum logic [2:0] {DirN, DirNE, DirE, DirSE, DirS, DirSW, DirW, DirNW} dir_e;

    typedef logic signed [6:0] offset_t;
    typedef logic signed [1:0] delta_t;

    localparam offset_t DIR_OFFSET [8] = '{-7'sd8, -7'sd7, 7'sd1, 7'sd9,
                                           7'sd8, 7'sd7, -7'sd1, -7'sd9};
    localparam delta_t  DIR_DCOL   [8] = '{2'sd0, 2'sd1, 2'sd1, 2'sd1,
                                           2'sd0, -2'sd1, -2'sd1, -2'sd1};

    typedef enum logic [2:0] {StIdle, StCheck, StScan, StFlip, StFinish} state_e;

    // Directions are ordered so that the reverse of d is always d+4 (mod 8).
    function automatic dir_e opposite(dir_e d);
        return dir_e'(d ^ 3'd4);
    endfunction

endpackage

// File: rtl/board_step.sv
// One step of a board walk: neighbouring cell index in a direction plus an edge-crossing flag.
module board_step
    import reversi_pkg::*;
(
    input  logic [5:0] index_i,
    input  dir_e       dir_i,
    output logic [5:0] next_index_o,
    output logic       off_board_o
);
    logic [7:0] lin;
    logic       row_off;
    logic       col_off;

    always_comb begin
        // Linear index with headroom: top bits set means the row left 0..7.
        lin          = {2'b00, index_i} + {DIR_OFFSET[dir_i][6], DIR_OFFSET[dir_i]};
        row_off      = (lin[7:6] != 2'b00);
        col_off      = ((DIR_DCOL[dir_i] == 2'sd1)  && (index_i[2:0] == 3'd7)) ||
                       ((DIR_DCOL[dir_i] == -2'sd1) && (index_i[2:0] == 3'd0));
        next_index_o = lin[5:0];
        off_board_o  = row_off || col_off;
    end

endmodule

// File: rtl/move_sequencer.sv
// Executes one Reversi move: occupancy check, eight-direction scan, flip write-back, target write.
module move_sequencer
    import reversi_pkg::*;
#(
    parameter int unsigned CELL_W = 3
) (
    input  logic                 clk,
    input  logic                 reseten,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [5:0]           req_index,
    input  logic                 req_player_black,
    input  logic [64*CELL_W-1:0] curr_board,
    output logic [64*CELL_W-1:0] result_board,
    output logic                 done,
    output logic                 legal,
    output logic [4:0]           flip_count,
    output logic                 next_player_black
);
    state_e             state_q, state_d;
    logic [BOARD_W-1:0] board_q, board_d;
    logic [5:0]         target_q, target_d;
    logic [5:0]         cur_q, cur_d;
    dir_e               dir_q, dir_d;
    logic [2:0]         run_q, run_d;
    logic [4:0]         flips_q, flips_d;
    logic               player_q, player_d;
    logic               legal_q, legal_d;
    logic               next_black_q, next_black_d;

    logic [2:0] own, opp, step_cell, target_cell;
    logic [5:0] step_next;
    logic       step_off, last_dir, target_occ, scan_opp, scan_cap, fin_legal;
    dir_e       step_dir;

    assign own         = player_q ? CELL_BLACK : CELL_WHITE;
    assign opp         = player_q ? CELL_WHITE : CELL_BLACK;
    assign step_dir    = (state_q == StFlip) ? opposite(dir_q) : dir_q;
    assign step_cell   = board_q[CELL_W*step_next +: CELL_W];
    assign target_cell = board_q[CELL_W*target_q +: CELL_W];
    assign target_occ  = (target_cell == CELL_BLACK) || (target_cell == CELL_WHITE);
    assign last_dir    = (dir_q == DirNW);
    assign scan_opp    = !step_off && (step_cell == opp);
    assign scan_cap    = !step_off && (step_cell == own) && (run_q != 3'd0);
    assign fin_legal   = (flips_q != 5'd0);

    board_step u_step (
        .index_i     (cur_q),
        .dir_i       (step_dir),
        .next_index_o(step_next),
        .off_board_o (step_off)
    );

    always_ff @(posedge clk or posedge reseten) begin
        if (reseten) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (req_valid) state_d = StCheck;
            StCheck:  state_d = target_occ ? StFinish : StScan;
            StScan: begin
                if (scan_cap) begin
                    state_d = StFlip;
                end else if (!scan_opp && last_dir) begin
                    state_d = StFinish;
                end
            end
            StFlip: begin
                if (run_q == 3'd1) state_d = last_dir ? StFinish : StScan;
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready         = (state_q == StIdle);
        done              = (state_q == StFinish);
        result_board      = board_q;
        legal             = legal_q;
        flip_count        = flips_q;
        next_player_black = next_black_q;
        if (done) begin
            legal             = fin_legal;
            next_player_black = fin_legal ? !player_q : player_q;
            if (fin_legal) result_board[CELL_W*target_q +: CELL_W] = own;
        end
    end

    always_comb begin
        board_d      = board_q;
        target_d     = target_q;
        cur_d        = cur_q;
        dir_d        = dir_q;
        run_d        = run_q;
        flips_d      = flips_q;
        player_d     = player_q;
        legal_d      = legal_q;
        next_black_d = next_black_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    board_d  = curr_board;
                    target_d = req_index;
                    player_d = req_player_black;
                    flips_d  = 5'd0;
                    legal_d  = 1'b0;
                end
            end
            StCheck: begin
                dir_d = DirN;
                cur_d = target_q;
                run_d = 3'd0;
            end
            StScan: begin
                if (scan_opp) begin
                    cur_d = step_next;
                    run_d = run_q + 3'd1;
                end else if (!scan_cap) begin
                    dir_d = dir_e'(dir_q + 3'd1);
                    cur_d = target_q;
                    run_d = 3'd0;
                end
            end
            StFlip: begin
                board_d[CELL_W*cur_q +: CELL_W] = own;
                flips_d = flips_q + 5'd1;
                cur_d   = step_next;
                run_d   = run_q - 3'd1;
                if (run_q == 3'd1) begin
                    dir_d = dir_e'(dir_q + 3'd1);
                    cur_d = target_q;
                end
            end
            StFinish: begin
                board_d      = result_board;
                legal_d      = legal;
                next_black_d = next_player_black;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reseten) begin
        if (reseten) begin
            board_q      <= {64{CELL_EMPTY}};
            target_q     <= 6'd0;
            cur_q        <= 6'd0;
            dir_q        <= DirN;
            run_q        <= 3'd0;
            flips_q      <= 5'd0;
            player_q     <= 1'b0;
            legal_q      <= 1'b0;
            next_black_q <= 1'b1;
        end else begin
            board_q      <= board_d;
            target_q     <= target_d;
            cur_q        <= cur_d;
            dir_q        <= dir_d;
            run_q        <= run_d;
            flips_q      <= flips_d;
            player_q     <= player_d;
            legal_q      <= legal_d;
            next_black_q <= next_black_d;
        end
    end

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: directed Reversi scenarios and random moves against a ray-walk model.
module tb_move_sequencer;
    logic         clk = 1'b0;
    logic         reseten;
    logic         req_valid;
    logic         req_ready;
    logic [5:0]   req_index;
    logic         req_player_black;
    logic [191:0] curr_board;
    logic [191:0] result_board;
    logic         done;
    logic         legal;
    logic [4:0]   flip_count;
    logic         next_player_black;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [2:0] BLK = 3'b111;
    localparam logic [2:0] WHT = 3'b110;
    localparam int DR [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};
    localparam int DC [8] = '{0, 1, 1, 1, 0, -1, -1, -1};

    always #5 clk = ~clk;

    move_sequencer #(.CELL_W(3)) dut (
        .clk              (clk),
        .reseten          (reseten),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_index        (req_index),
        .req_player_black (req_player_black),
        .curr_board       (curr_board),
        .result_board     (result_board),
        .done             (done),
        .legal            (legal),
        .flip_count       (flip_count),
        .next_player_black(next_player_black)
    );

    task automatic chk_v(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // Walks each ray on a row/column grid; latency = 2 + steps attempted + cells flipped.
    task automatic model(input logic [191:0] b, input int idx, input bit black,
                         output logic [191:0] nb, output int nflips, output bit lg,
                         output int lat);
        logic [2:0] own, opp, c;
        int r0, c0;
        own    = black ? BLK : WHT;
        opp    = black ? WHT : BLK;
        nb     = b;
        nflips = 0;
        lat    = 2;
        lg     = 1'b0;
        c      = b[3*idx +: 3];
        if (c == BLK || c == WHT) return;
        r0 = idx / 8;
        c0 = idx % 8;
        for (int d = 0; d < 8; d++) begin
            int r, cc, n;
            bit stop;
            r = r0; cc = c0; n = 0; stop = 1'b0;
            while (!stop) begin
                r  += DR[d];
                cc += DC[d];
                lat++;
                if (r < 0 || r > 7 || cc < 0 || cc > 7) begin
                    stop = 1'b1;
                end else if (b[3*(r*8+cc) +: 3] == opp) begin
                    n++;
                end else begin
                    if (b[3*(r*8+cc) +: 3] == own && n > 0) begin
                        for (int k = 1; k <= n; k++)
                            nb[3*((r0+k*DR[d])*8 + c0+k*DC[d]) +: 3] = own;
                        nflips += n;
                        lat    += n;
                    end
                    stop = 1'b1;
                end
            end
        end
        lg = (nflips > 0);
        if (lg) nb[3*idx +: 3] = own;
    endtask

    task automatic do_move(input string tag, input logic [191:0] b, input int idx,
                           input bit black, output int lat, output logic [191:0] ob,
                           output int fl, output bit lg, output bit nxb);
        logic [191:0] eb;
        int ef, elat, cyc;
        bit el;
        model(b, idx, black, eb, ef, el, elat);
        cyc = 0;
        while (!req_ready && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        curr_board       = b;
        req_index        = 6'(idx);
        req_player_black = black;
        req_valid        = 1'b1;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        curr_board = {6{$urandom()}};
        cyc = 1;
        chk_i({tag, " ready busy"}, int'(req_ready), 0);
        while (!done && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        lat = cyc;
        ob  = result_board;
        fl  = int'(flip_count);
        lg  = legal;
        nxb = next_player_black;
        chk_i({tag, " latency"}, lat, elat);
        chk_v({tag, " board"}, ob, eb);
        chk_i({tag, " flips"}, fl, ef);
        chk_i({tag, " legal"}, int'(lg), int'(el));
        chk_i({tag, " next player"}, int'(nxb), int'(el ? !black : black));
        @(posedge clk); #1;
        chk_i({tag, " done pulse"}, int'(done), 0);
        chk_i({tag, " legal held"}, int'(legal), int'(el));
        chk_i({tag, " flips held"}, int'(flip_count), ef);
        chk_v({tag, " board held"}, result_board, eb);
    endtask

    initial begin
        logic [191:0] b, ob;
        int lat, fl, r;
        bit lg, nxb;

        reseten          = 1'b1;
        req_valid        = 1'b0;
        req_index        = 6'd0;
        req_player_black = 1'b0;
        curr_board       = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_i("reset ready", int'(req_ready), 1);
        chk_i("reset done", int'(done), 0);
        chk_i("reset legal", int'(legal), 0);
        chk_i("reset flips", int'(flip_count), 0);
        chk_i("reset next player", int'(next_player_black), 1);
        chk_v("reset board", result_board, '0);
        reseten = 1'b0;
        @(posedge clk); #1;

        b = '0;
        b[3*27 +: 3] = WHT; b[3*36 +: 3] = WHT;
        b[3*28 +: 3] = BLK; b[3*35 +: 3] = BLK;
        do_move("open19", b, 19, 1'b1, lat, ob, fl, lg, nxb);
        chk_i("open19 done cycle", lat, 12);
        chk_v("open19 cell27", 192'(ob[3*27 +: 3]), 192'(BLK));
        chk_v("open19 cell19", 192'(ob[3*19 +: 3]), 192'(BLK));
        chk_i("open19 count", fl, 1);
        chk_i("open19 legal flag", int'(lg), 1);
        chk_i("open19 next", int'(nxb), 0);

        do_move("open27", b, 27, 1'b1, lat, ob, fl, lg, nxb);
        chk_i("open27 done cycle", lat, 2);
        chk_v("open27 unchanged", ob, b);
        chk_i("open27 legal flag", int'(lg), 0);
        chk_i("open27 next", int'(nxb), 1);

        b = '0;
        b[3*1 +: 3] = WHT;
        do_move("lone", b, 0, 1'b1, lat, ob, fl, lg, nxb);
        chk_v("lone unchanged", ob, b);
        chk_i("lone count", fl, 0);

        b = '0;
        b[3*7 +: 3] = BLK; b[3*8 +: 3] = WHT;
        do_move("wrap", b, 9, 1'b1, lat, ob, fl, lg, nxb);
        chk_v("wrap unchanged", ob, b);
        chk_i("wrap legal flag", int'(lg), 0);

        b = '0;
        for (int i = 1; i <= 6; i++) b[3*i +: 3] = WHT;
        b[3*7 +: 3] = BLK; b[3*9 +: 3] = WHT; b[3*18 +: 3] = BLK;
        do_move("multi", b, 0, 1'b1, lat, ob, fl, lg, nxb);
        chk_i("multi count", fl, 7);
        chk_i("multi legal flag", int'(lg), 1);
        chk_i("multi done cycle", lat, 24);

        // Reset while the east run is being flipped (cycles 11..16 of this move).
        curr_board       = b;
        req_index        = 6'd0;
        req_player_black = 1'b1;
        req_valid        = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            chk_i("midmove no done", int'(done), 0);
        end
        reseten = 1'b1;
        #1;
        chk_i("midrst ready", int'(req_ready), 1);
        chk_i("midrst done", int'(done), 0);
        chk_i("midrst legal", int'(legal), 0);
        chk_i("midrst flips", int'(flip_count), 0);
        chk_i("midrst next", int'(next_player_black), 1);
        chk_v("midrst board", result_board, '0);
        @(posedge clk); #1;
        chk_i("midrst held done", int'(done), 0);
        reseten = 1'b0;
        @(posedge clk); #1;
        chk_i("post rst done", int'(done), 0);
        do_move("after rst", b, 0, 1'b1, lat, ob, fl, lg, nxb);

        for (int t = 0; t < 40; t++) begin
            b = '0;
            for (int i = 0; i < 64; i++) begin
                r = int'($urandom_range(0, 9));
                b[3*i +: 3] = (r < 4) ? 3'b000 : (r < 7) ? BLK : (r < 9) ? WHT : 3'b011;
            end
            do_move("rnd", b, int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                    lat, ob, fl, lg, nxb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
